// File: rtl/nn_zoffset_multi_pkg.sv
// nn_zoffset_multi_pkg: shared LFSR, rotation and saturation definitions for the z-offset block
package nn_zoffset_multi_pkg;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'd13441;
  localparam int ROT_STEP = 3;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
  function automatic logic [15:0] rotl16(input logic [15:0] s, input int n);
    logic [31:0] x;
    x = {s, s} << n;
    return x[31:16];
  endfunction
  function automatic int sat_lim(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/nn_zoffset_lane.sv
// nn_zoffset_lane: one channel's signed residual accumulator and output decision
// ports: clk, rst_n (async low); en advance; z/sign_z stochastic input; d/d_sign offset bit; zd/sign_zd registered output
module nn_zoffset_lane
  import nn_zoffset_multi_pkg::*;
#(
  parameter int ACC_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic z,
  input  logic sign_z,
  input  logic d,
  input  logic d_sign,
  output logic zd,
  output logic sign_zd
);
  localparam int TW = ACC_W + 2;
  localparam logic signed [TW-1:0] ONE = 1;
  localparam logic signed [TW-1:0] ZERO = 0;
  localparam logic signed [TW-1:0] LIM = TW'(sat_lim(ACC_W));
  logic signed [ACC_W-1:0] acc;
  logic signed [TW-1:0] cz, cd, t, n, s;
  always_comb begin
    cz = z ? (sign_z ? -ONE : ONE) : ZERO;
    cd = d ? (d_sign ? -ONE : ONE) : ZERO;
    t = TW'(acc) + cz + cd;
    n = t > ZERO ? t - ONE : t < ZERO ? t + ONE : ZERO;
    s = n > LIM ? LIM : n < -LIM ? -LIM : n;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      zd <= 1'b0;
      sign_zd <= 1'b0;
    end else if (en) begin
      acc <= s[ACC_W-1:0];
      zd <= t != ZERO;
      sign_zd <= t < ZERO;
    end
endmodule

// File: rtl/nn_zoffset_multi.sv
// nn_zoffset_multi: adds a configurable stochastic offset d to N_CH stochastic z streams
// ports: clk, rst_n (async low); en advance; z/sign_z per channel; cfg_we/cfg_ch/cfg_mag/cfg_sign shadow write;
// commit copies shadow to active; zd/sign_zd registered per-channel result
module nn_zoffset_multi
  import nn_zoffset_multi_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W_OFF = 8,
  parameter int ACC_W = 4,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH-1:0]         z,
  input  logic [N_CH-1:0]         sign_z,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [W_OFF-1:0]        cfg_mag,
  input  logic                    cfg_sign,
  input  logic                    commit,
  output logic [N_CH-1:0]         zd,
  output logic [N_CH-1:0]         sign_zd
);
  typedef struct packed {
    logic sign;
    logic [W_OFF-1:0] mag;
  } off_t;
  off_t shadow [N_CH];
  off_t active [N_CH];
  logic [N_CH-1:0] hit;
  logic [15:0] lfsr;
  always_comb begin
    hit = '0;
    if (cfg_we && int'(cfg_ch) < N_CH) hit[cfg_ch] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= SEED == 16'd0 ? 16'h0001 : SEED;
    else if (en) lfsr <= lfsr_next(lfsr);
  // a write landing in the commit cycle bypasses shadow straight into active
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (hit[i]) shadow[i] <= {cfg_sign, cfg_mag};
        if (commit) active[i] <= hit[i] ? {cfg_sign, cfg_mag} : shadow[i];
      end
    end
  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    logic [15:0] rot;
    logic d;
    assign rot = rotl16(lfsr, (ROT_STEP * g) % 16);
    assign d = rot[15 -: W_OFF] < active[g].mag;
    nn_zoffset_lane #(.ACC_W(ACC_W)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .z(z[g]),
      .sign_z(sign_z[g]),
      .d(d),
      .d_sign(active[g].sign),
      .zd(zd[g]),
      .sign_zd(sign_zd[g])
    );
  end
endmodule

// File: tb/tb_nn_zoffset_multi.sv
// tb_nn_zoffset_multi: directed vector bench for nn_zoffset_multi with an LFSR reference model
module tb_nn_zoffset_multi;
  logic clk = 0, rst_n = 0, en = 0, cfg_we = 0, cfg_sign = 0, commit = 0;
  logic [3:0] z = 0, sign_z = 0, zd, sign_zd;
  logic [1:0] cfg_ch = 0;
  logic [7:0] cfg_mag = 0;
  logic [15:0] lm;
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0] z, sz, ezd, esz;
  } vec_t;
  vec_t tbl [9];
  nn_zoffset_multi dut (
    .clk(clk), .rst_n(rst_n), .en(en), .z(z), .sign_z(sign_z),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mag(cfg_mag), .cfg_sign(cfg_sign),
    .commit(commit), .zd(zd), .sign_zd(sign_zd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (en) lm = {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
    #1;
  endtask
  function automatic logic dbit(input int ch, input int mag);
    logic [31:0] x;
    x = {lm, lm} << ((3 * ch) % 16);
    return int'(x[31:24]) < mag;
  endfunction
  task automatic cfg(input logic [1:0] ch, input logic [7:0] mag, input logic sg, input logic com);
    cfg_we = 1; cfg_ch = ch; cfg_mag = mag; cfg_sign = sg; commit = com;
    tick();
    cfg_we = 0; commit = 0;
  endtask
  initial begin
    int ones, mism, macc, t;
    logic e2, e3;
    logic [3:0] ezd;
    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tbl[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tbl[3] = '{4'b1111, 4'b1010, 4'b1111, 4'b1010};
    tbl[4] = '{4'b1111, 4'b0101, 4'b1111, 4'b0101};
    tbl[5] = '{4'b1111, 4'b1010, 4'b1111, 4'b1010};
    tbl[6] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
    tbl[7] = '{4'b0110, 4'b0100, 4'b0110, 4'b0100};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    #12;
    chk("reset_zd", 32'(zd), 0);
    chk("reset_sign_zd", 32'(sign_zd), 0);
    @(negedge clk);
    rst_n = 1; en = 1; lm = 16'd13441;
    foreach (tbl[i]) begin
      z = tbl[i].z; sign_z = tbl[i].sz;
      tick();
      chk($sformatf("vec%0d_zd", i), 32'(zd), 32'(tbl[i].ezd));
      chk($sformatf("vec%0d_sign_zd", i), 32'(sign_zd), 32'(tbl[i].esz));
    end
    cfg(2'd1, 8'd255, 1'b0, 1'b1);
    z = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("ramp_ch1", {zd[1], sign_zd[1]}, 2'b10);
    end
    cfg(2'd1, 8'd0, 1'b0, 1'b1);
    z = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("drain_ch1_%0d", i), {zd[1], sign_zd[1]}, i < 7 ? 2'b10 : 2'b00);
    end
    cfg(2'd2, 8'd128, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("shadow_only", 32'(zd), 0);
    end
    cfg(2'd2, 8'd200, 1'b0, 1'b1);
    ones = 0; mism = 0;
    for (int i = 0; i < 4096; i++) begin
      e2 = dbit(2, 200);
      tick();
      ones += int'(zd[2]);
      if (zd[2] !== e2) mism++;
    end
    chk("rate_exact_mismatches", 32'(mism), 0);
    chk("rate_in_range", 32'(ones >= 3077 && ones <= 3323), 1);
    z = 4'b0001; sign_z = 4'b0000;
    e2 = dbit(2, 200);
    tick();
    ezd = {1'b0, e2, 2'b01};
    chk("pre_freeze_zd", 32'(zd), 32'(ezd));
    en = 0;
    for (int i = 0; i < 10; i++) begin
      z = 4'(i * 5 + 3); sign_z = 4'(~i);
      if (i == 3) begin
        cfg_we = 1; cfg_ch = 2'd3; cfg_mag = 8'd255; cfg_sign = 1; commit = 1;
      end
      tick();
      cfg_we = 0; commit = 0;
      chk("freeze_zd", 32'(zd), 32'(ezd));
      chk("freeze_sign_zd", 32'(sign_zd), 0);
    end
    en = 1; z = 4'b0001; sign_z = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      e2 = dbit(2, 200); e3 = dbit(3, 255);
      tick();
      chk("resume_zd", 32'(zd), 32'({e3, e2, 2'b01}));
      chk("resume_sign_zd", 32'(sign_zd), 32'({e3, 3'b000}));
    end
    z = 4'b0000;
    cfg(2'd0, 8'd255, 1'b1, 1'b1);
    z = 4'b0001; sign_z = 4'b0001; macc = 0;
    for (int i = 0; i < 12 && macc != -5; i++) begin
      t = macc - 1 - (dbit(0, 255) ? 1 : 0);
      macc = t > 0 ? t - 1 : t < 0 ? t + 1 : 0;
      macc = macc > 7 ? 7 : macc < -7 ? -7 : macc;
      tick();
      chk("neg_ramp_ch0", {zd[0], sign_zd[0]}, {t != 0, t < 0});
    end
    if (macc != -5) begin
      tests++; fails++;
      $display("FAIL neg_ramp_bound: acc model %0d, required -5", macc);
    end
    #2 rst_n = 0;
    #1;
    chk("midreset_zd", 32'(zd), 0);
    chk("midreset_sign_zd", 32'(sign_zd), 0);
    z = 0; sign_z = 0;
    @(negedge clk);
    rst_n = 1; lm = 16'd13441;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_residue", {28'd0, zd | sign_zd}, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
